// File: rtl/cam_timing_gen.sv
// cam_timing_gen: parametrised camera-bus source producing pclk/vsync/href/data
// in the same shape a sensor drives, with geometry, clock divider, test
// patterns, frame counting and enable gating.
// Optional feature macro: PATTERN_BALL_EN (mode 3 draws a moving 8x8 square).
module cam_timing_gen #(
  parameter int PCLK_DIV = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int BPP      = 2,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 3,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int BAR_PIX = H_ACTIVE / 8;
  localparam int V_M01   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_M23   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX   = (V_M01 > V_M23) ? V_M01 : V_M23;
  localparam int DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int PIX_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int BYTE_W  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int BARP_W  = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;
  localparam int LINE_W  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_BACK, ST_ACTIVE, ST_FRONT
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                pclk_q, pclk_d;
  logic                first_q, first_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [BYTE_W-1:0]   bsel_q, bsel_d;
  logic [7:0]          inc_q, inc_d;
  logic [2:0]          bar_q, bar_d;
  logic [BARP_W-1:0]   barp_q, barp_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         color_q, color_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic [7:0]          data_q, data_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
`ifdef PATTERN_BALL_EN
  logic [PIX_W-1:0]    bx_q, bx_d;
  logic [LINE_W-1:0]   by_q, by_d;
  logic                in_ball;
`endif

  logic                div_wrap;
  logic                eol;
  logic [LINE_W-1:0]   seg_last;
  logic [15:0]         pcol;
  logic [7:0]          pbyte;

  // Colour bar palette, left to right
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Next-state: divider, position counters, frame sequencing and the pixel
  // outputs. Positions only advance on pclk falls; the first fall after a
  // start just presents position 0 so vsync rises on that fall.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    pclk_d       = pclk_q;
    first_d      = first_q;
    line_d       = line_q;
    pix_d        = pix_q;
    bsel_d       = bsel_q;
    inc_d        = inc_q;
    bar_d        = bar_q;
    barp_d       = barp_q;
    mode_d       = mode_q;
    color_d      = color_q;
    vsync_d      = vsync_q;
    href_d       = href_q;
    data_d       = data_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
`ifdef PATTERN_BALL_EN
    bx_d         = bx_q;
    by_d         = by_q;
    in_ball      = 1'b0;
`endif
    eol      = 1'b0;
    pcol     = 16'h0000;
    pbyte    = 8'h00;
    div_wrap = (div_q == DIV_W'(PCLK_DIV - 1));

    case (state_q)
      ST_VSYNC:  seg_last = LINE_W'(V_SYNC - 1);
      ST_BACK:   seg_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE: seg_last = LINE_W'(V_ACTIVE - 1);
      default:   seg_last = LINE_W'(V_FRONT - 1);
    endcase

    if (state_q == ST_IDLE) begin
      pclk_d = 1'b1;
      div_d  = '0;
      if (enable) begin
        state_d = ST_VSYNC;
        busy_d  = 1'b1;
        first_d = 1'b1;
        line_d  = '0;
        pix_d   = '0;
        bsel_d  = '0;
        inc_d   = '0;
        bar_d   = '0;
        barp_d  = '0;
        mode_d  = mode;
        color_d = color;
      end
    end else begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) pclk_d = ~pclk_q;

      if (div_wrap && pclk_q) begin
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          // byte -> pixel -> line -> segment carry chain
          if (bsel_q != BYTE_W'(BPP - 1)) begin
            bsel_d = bsel_q + BYTE_W'(1);
          end else begin
            bsel_d = '0;
            if (pix_q != PIX_W'(H_TOTAL - 1)) begin
              pix_d = pix_q + PIX_W'(1);
              if (barp_q == BARP_W'(BAR_PIX - 1)) begin
                barp_d = '0;
                bar_d  = bar_q + 3'd1;
              end else begin
                barp_d = barp_q + BARP_W'(1);
              end
            end else begin
              pix_d  = '0;
              barp_d = '0;
              bar_d  = '0;
              eol    = 1'b1;
            end
          end
          inc_d = eol ? 8'h00 : inc_q + 8'h01;

          if (eol) begin
            if (line_q != seg_last) begin
              line_d = line_q + LINE_W'(1);
            end else begin
              line_d = '0;
              case (state_q)
                ST_VSYNC:  state_d = ST_BACK;
                ST_BACK:   state_d = ST_ACTIVE;
                ST_ACTIVE: state_d = ST_FRONT;
                default: begin
                  // frame end: count, move the ball, restart or park
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'h0001;
`ifdef PATTERN_BALL_EN
                  bx_d = (bx_q == PIX_W'(H_ACTIVE - 8)) ? '0 : bx_q + PIX_W'(1);
                  by_d = (by_q == LINE_W'(V_ACTIVE - 8)) ? '0 : by_q + LINE_W'(1);
`endif
                  if (enable) begin
                    state_d = ST_VSYNC;
                    mode_d  = mode;
                    color_d = color;
                  end else begin
                    state_d = ST_IDLE;
                  end
                end
              endcase
            end
          end
        end

        if (state_d == ST_IDLE) begin
          // parking: skip this fall so pclk stays high while idle
          pclk_d  = 1'b1;
          busy_d  = 1'b0;
          vsync_d = 1'b0;
          href_d  = 1'b0;
          data_d  = 8'h00;
        end else begin
          case (mode_q)
            2'd2:    pcol = bar_color(bar_d);
`ifdef PATTERN_BALL_EN
            2'd3: begin
              in_ball = ({1'b0, pix_d} >= {1'b0, bx_q}) &&
                        ({1'b0, pix_d} < ({1'b0, bx_q} + (PIX_W+1)'(8))) &&
                        ({1'b0, line_d} >= {1'b0, by_q}) &&
                        ({1'b0, line_d} < ({1'b0, by_q} + (LINE_W+1)'(8)));
              pcol = in_ball ? color_q : 16'h0000;
            end
`endif
            default: pcol = color_q;
          endcase
          if (mode_q == 2'd0)                 pbyte = inc_d;
          else if (bsel_d == BYTE_W'(0))      pbyte = pcol[15:8];
          else if (bsel_d == BYTE_W'(1))      pbyte = pcol[7:0];
          else                                pbyte = 8'h00;

          vsync_d = (state_d == ST_VSYNC);
          href_d  = (state_d == ST_ACTIVE) &&
                    ({1'b0, pix_d} < (PIX_W+1)'(H_ACTIVE));
          data_d  = href_d ? pbyte : 8'h00;
        end
      end
    end
  end

  // State and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      pclk_q       <= 1'b1;
      first_q      <= 1'b0;
      line_q       <= '0;
      pix_q        <= '0;
      bsel_q       <= '0;
      inc_q        <= 8'h00;
      bar_q        <= 3'd0;
      barp_q       <= '0;
      mode_q       <= 2'd0;
      color_q      <= 16'h0000;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      frame_cnt_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PATTERN_BALL_EN
      bx_q         <= '0;
      by_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      pclk_q       <= pclk_d;
      first_q      <= first_d;
      line_q       <= line_d;
      pix_q        <= pix_d;
      bsel_q       <= bsel_d;
      inc_q        <= inc_d;
      bar_q        <= bar_d;
      barp_q       <= barp_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef PATTERN_BALL_EN
      bx_q         <= bx_d;
      by_q         <= by_d;
`endif
    end
  end

  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/cam_timing_gen.md
Name: cam_timing_gen

Overview:
- Synthesisable, parametrised camera-bus source: drives pclk/vsync/href/data with the same waveform shape the ball detector front end consumes.
- Sits in front of the detector's camera input, muxed against the real sensor pins, for on-board self-test and simulation.
- Adds programmable geometry, a clock divider, several pixel patterns, frame counting and enable gating.

Parameters:
- PCLK_DIV, 16, clk cycles per pclk half-period (>=1)
- H_ACTIVE, 640, active pixels per line (multiple of 8)
- H_BLANK, 144, blank pixels per line
- BPP, 2, bytes per pixel (pclk cycles per pixel)
- V_SYNC, 1, lines with vsync high
- V_BACK, 3, lines after vsync before first active line
- V_ACTIVE, 480, active lines
- V_FRONT, 10, lines after last active line

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run request
- mode  in  2  0 = incrementing byte, 1 = solid colour, 2 = colour bars, 3 = ball
- color  in  16  RGB565 for modes 1 and 3
- pclk  out  1  generated pixel clock
- vsync  out  1  frame sync
- href  out  1  line valid
- data  out  8  pixel byte
- frame_cnt  out  16  completed frames
- frame_done  out  1  one-clk pulse at frame end
- busy  out  1  frame in progress

Behaviour:
- Reset (synchronous; wins over everything, including mid-frame):
  - pclk=1, vsync=0, href=0, data=0, frame_cnt=0, frame_done=0, busy=0.
  - All counters and the ball position return to 0.
- pclk generation:
  - Divider counts 0..PCLK_DIV-1 and toggles pclk on wrap while busy.
  - When idle, pclk is held at 1.
- Update timing:
  - All of vsync, href and data change only on the clk edge that drives pclk 1->0.
  - They are stable across the pclk rising edge.
- Line length: Tline = (H_ACTIVE + H_BLANK) * BPP pclk cycles.
- Frame sequence, counted in Tline units:
  - vsync=1 for V_SYNC lines.
  - vsync=0 for V_BACK lines.
  - V_ACTIVE lines: href=1 for H_ACTIVE*BPP pclks, then href=0 for H_BLANK*BPP pclks.
  - V_FRONT lines.
- State machine IDLE -> VSYNC -> BACK -> ACTIVE -> FRONT:
  - IDLE->VSYNC on enable=1; vsync rises at the first pclk fall.
  - FRONT->VSYNC on frame end if enable=1, otherwise FRONT->IDLE.
  - enable is sampled only in IDLE and at frame end. Deasserting it mid-frame completes the frame.
  - busy=1 in every state except IDLE.
- Data rules:
  - data=0 whenever href=0; never X.
  - Mode 0: data=0 on the first href byte of each line, +1 per pclk, wraps 255->0.
  - Modes 1-3, per pixel: byte 0 = colour[15:8], byte 1 = colour[7:0]. Extra bytes when BPP>2 are 0.
  - Mode 2: eight bars of H_ACTIVE/8 pixels each, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index comes from a pixel counter (no divider).
  - Mode 3 without PATTERN_BALL_EN: behaves as mode 1.
- mode and color are latched at frame start and are stable for the whole frame.
- Frame end:
  - Occurs on the last pclk fall of FRONT.
  - frame_done pulses for 1 clk.
  - frame_cnt increments, wrapping 65535->0.
- Counter widths: $clog2 of each maximum, no overflow.

Optional Feature:
PATTERN_BALL_EN
- Defined: mode 3 draws an 8x8-pixel square in colour on a 0000 background.
  - Top-left corner is at (bx, by). Both start at 0.
  - At each frame end, bx += 1 and by += 1.
  - bx wraps to 0 after H_ACTIVE-8; by wraps to 0 after V_ACTIVE-8, independently.
  - Gives the detector a moving target.
- Undefined: no position registers; mode 3 = mode 1.

Test Plan:
- Parameters for all scenarios below: PCLK_DIV=2, H_ACTIVE=8, H_BLANK=2, BPP=2, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1.
  - One frame = 5 lines x 20 pclk = 100 pclk = 400 clk.
- Reset, then enable=1, mode=0:
  - vsync high for 20 pclk, low for 20.
  - href high for 16 pclk with data 00..0F, then 4 pclk of 00.
  - Same for line 2.
  - frame_done pulses at clk 400 after start; frame_cnt=1.
- Mode 2, two frames:
  - Each active line byte stream is FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
  - data sampled only on pclk rise is stable.
- enable dropped at pclk 30 of frame 1:
  - Frame completes fully, then busy=0 and pclk held at 1.
  - frame_cnt=1 and no further vsync.
- rst asserted mid-ACTIVE:
  - Next clk: href=0, data=0, vsync=0, pclk=1, frame_cnt=0.
  - With enable=1 after release, a full frame restarts from VSYNC.
- PATTERN_BALL_EN, H_ACTIVE=16, V_ACTIVE=16, mode=3, color=F800:
  - Frame 0: bytes F8 00 at pixels 0-7 of lines 0-7, 00 elsewhere.
  - Frame 1: square at (1,1).
  - Frame 9: bx=by=0 (wrap after 8).
